// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: walks the PC through a combinational ROM, buffers
// fetched words in a small prefetch queue and hands them out over valid/ready.
module imem_fetch_ctrl #(
    parameter int              N         = 32,
    parameter int              PC_W      = 64,
    parameter int              DEPTH     = 4,
    parameter logic [PC_W-1:0] RESET_PC  = 64'h0,
    parameter logic [N-1:0]    HALT_WORD = 32'hb400001f
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    output logic [6:0]      imem_addr,
    input  logic [N-1:0]    imem_q,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            halted,
    output logic            dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    // Handshake: a head entry transfers on any rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and the head stays stable while stalled.

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    state_t          state_q, state_d;
    logic            halted_q, halted_d;

    logic [PC_W-1:0] pc_mem_q    [DEPTH];
    logic [N-1:0]    instr_mem_q [DEPTH];

    logic pop;
    logic push;
    logic unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    assign pop  = (count_q != '0) && out_ready;
    // Full queue can still accept a word when the head leaves in the same cycle.
    assign push = (state_q == ST_RUN) && fetch_en && !redirect_valid &&
                  ((count_q != CW'(DEPTH)) || pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        state_d    = state_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            state_d    = ST_RUN;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                fetch_pc_d = fetch_pc_q + PC_W'(4);
                if (imem_q == HALT_WORD) begin
                    state_d = ST_HALT;
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        halted_d = (state_d == ST_HALT) && (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            state_q    <= ST_RUN;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            state_q    <= state_d;
            halted_q   <= halted_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
                instr_mem_q[wr_ptr_q] <= imem_q;
            end
        end
    end

    assign imem_addr = fetch_pc_q[8:2];
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign halted    = halted_q;
    assign dbg_state = state_q;

endmodule
